// File: rtl/proc_multicycle_p_if.sv
// Tester-facing bus of proc_multicycle_p: instruction/immediate input, step enable,
// completion flag and the shared-bus value.
interface proc_multicycle_p_if #(
  parameter int unsigned DATA_W = 16
);
  logic [DATA_W-1:0] DIN;
  logic              Run;
  logic              Done;
  logic [DATA_W-1:0] BusWires;

  modport master (output DIN, output Run, input Done, input BusWires);
  modport slave  (input DIN, input Run, output Done, output BusWires);
endinterface

// File: rtl/proc_multicycle_p.sv
// Parametrised multicycle processor: shared bus, register file, A/G accumulators, T0-T3 step FSM.
// Optional conditional move (opcode 8) enabled by defining PROC_MVNZ_EN.
module proc_multicycle_p #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RAW    = 3
) (
  input logic             Clock,
  input logic             Reset,
  proc_multicycle_p_if.slave io
);
  localparam int unsigned NREGS = 2**RAW;
  localparam int unsigned IW    = 4 + 2*RAW;

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  state_t            state, nxt;
  logic [IW-1:0]     ir;
  logic [DATA_W-1:0] r [NREGS];
  logic [DATA_W-1:0] a, g, bus, alu;
  logic              done, wr_rx, ld_a, ld_g;
  logic [3:0]        op;
  logic [RAW-1:0]    x, y;

  assign op = ir[IW-1 -: 4];
  assign x  = ir[2*RAW-1 -: RAW];
  assign y  = ir[RAW-1:0];

  // Bus source, write enables and next step for the current state/opcode
  always_comb begin
    bus   = '0;
    done  = 1'b0;
    wr_rx = 1'b0;
    ld_a  = 1'b0;
    ld_g  = 1'b0;
    nxt   = state;
    case (state)
      T0: nxt = T1;
      T1: begin
        nxt  = T0;
        done = 1'b1;
        case (op)
          4'd0: begin
            bus   = r[y];
            wr_rx = 1'b1;
          end
          4'd1: begin
            bus   = io.DIN;
            wr_rx = 1'b1;
          end
          4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
            bus  = r[x];
            ld_a = 1'b1;
            done = 1'b0;
            nxt  = T2;
          end
`ifdef PROC_MVNZ_EN
          4'd8: begin
            bus   = r[y];
            wr_rx = (g != '0);
          end
`endif
          default: bus = '0;
        endcase
      end
      T2: begin
        bus  = r[y];
        ld_g = 1'b1;
        nxt  = T3;
      end
      T3: begin
        bus   = g;
        wr_rx = 1'b1;
        done  = 1'b1;
        nxt   = T0;
      end
      default: nxt = T0;
    endcase
  end

  // ALU: A op bus; shifts by DATA_W or more yield zero
  always_comb begin
    alu = '0;
    case (op)
      4'd2: alu = a + bus;
      4'd3: alu = a - bus;
      4'd4: alu = a & bus;
      4'd5: alu = DATA_W'(a < bus);
      4'd6: alu = (bus >= DATA_W'(DATA_W)) ? '0 : (a << bus);
      4'd7: alu = (bus >= DATA_W'(DATA_W)) ? '0 : (a >> bus);
      default: alu = '0;
    endcase
  end

  // All state holds while Run is low
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= T0;
      ir    <= '0;
      a     <= '0;
      g     <= '0;
      for (int i = 0; i < int'(NREGS); i++) r[i] <= '0;
    end else if (io.Run) begin
      state <= nxt;
      if (state == T0) ir <= io.DIN[IW-1:0];
      if (ld_a) a <= bus;
      if (ld_g) g <= alu;
      if (wr_rx) r[x] <= bus;
    end
  end

  assign io.Done     = done & io.Run;
  assign io.BusWires = bus;
endmodule

// File: tb/tb_proc_multicycle_p.sv
// Directed self-checking bench for proc_multicycle_p (DATA_W=16, RAW=3).
module tb_proc_multicycle_p;
  logic Clock = 1'b0;
  logic Reset;
  int   checks   = 0;
  int   failures = 0;

  proc_multicycle_p_if #(.DATA_W(16)) io ();

  proc_multicycle_p #(.DATA_W(16), .RAW(3)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .io    (io)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ins(input int op, input int x, input int y);
    logic [9:0] v;
    v = {op[3:0], x[2:0], y[2:0]};
    return 16'(v);
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Runs one instruction with Run high, checking Done only on the n-th cycle
  task automatic exec(input string tag, input int op, input int x, input int y,
                      input logic [15:0] imm, input int n);
    io.DIN = ins(op, x, y);
    io.Run = 1'b1;
    for (int c = 1; c <= n; c++) begin
      #1;
      chk({tag, ".done"}, 16'(io.Done), (c == n) ? 16'd1 : 16'd0);
      @(posedge Clock);
      #1;
      io.DIN = imm;
    end
  endtask

  // Reads Rr through "mv Rr,Rr": the T1 bus carries the register value
  task automatic rd(input string tag, input int rr, input logic [15:0] exp);
    io.DIN = ins(0, rr, rr);
    io.Run = 1'b1;
    tick();
    #1;
    chk(tag, io.BusWires, exp);
    chk({tag, ".done"}, 16'(io.Done), 16'd1);
    tick();
  endtask

  initial begin
    Reset  = 1'b1;
    io.Run = 1'b0;
    io.DIN = '0;
    #1;
    chk("rst.done", 16'(io.Done), 16'd0);
    chk("rst.bus", io.BusWires, 16'd0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;

    // mvi then add
    exec("mvi_r0", 1, 0, 0, 16'd5, 2);
    exec("mvi_r1", 1, 1, 0, 16'd7, 2);
    exec("add", 2, 0, 1, 16'd0, 4);
    io.DIN = ins(0, 2, 0);
    tick();
    #1;
    chk("mv_r2_r0.bus", io.BusWires, 16'h000C);
    tick();
    rd("rd_r2", 2, 16'h000C);

    // wrap and shifts
    exec("mvi_ffff", 1, 0, 0, 16'hFFFF, 2);
    exec("mvi_1", 1, 1, 0, 16'h0001, 2);
    exec("add_wrap", 2, 0, 1, 16'd0, 4);
    rd("rd_wrap", 0, 16'h0000);
    exec("mvi_r3", 1, 3, 0, 16'h8000, 2);
    exec("mvi_r4", 1, 4, 0, 16'd16, 2);
    exec("sll16", 6, 3, 4, 16'd0, 4);
    rd("rd_sll16", 3, 16'h0000);
    exec("mvi_r3b", 1, 3, 0, 16'h8000, 2);
    exec("mvi_r4b", 1, 4, 0, 16'd15, 2);
    exec("srl15", 7, 3, 4, 16'd0, 4);
    rd("rd_srl15", 3, 16'h0001);
    exec("sll15", 6, 3, 4, 16'd0, 4);
    rd("rd_sll15", 3, 16'h8000);

    // slt and sub
    exec("mvi_3", 1, 0, 0, 16'd3, 2);
    exec("mvi_9", 1, 1, 0, 16'd9, 2);
    exec("slt_t", 5, 0, 1, 16'd0, 4);
    rd("rd_slt_t", 0, 16'h0001);
    exec("mvi_r5", 1, 5, 0, 16'd2, 2);
    exec("sub", 3, 5, 1, 16'd0, 4);
    rd("rd_sub", 5, 16'hFFF9);
    exec("slt_f", 5, 1, 0, 16'd0, 4);
    rd("rd_slt_f", 1, 16'h0000);

    // mvnz with G = 0: never writes
    exec("mvnz_g0", 8, 0, 1, 16'd0, 2);
    rd("rd_mvnz_g0", 0, 16'h0001);

    // mvnz with G = 1
    exec("mvi_r6", 1, 6, 0, 16'd1, 2);
    exec("mvi_r7", 1, 7, 0, 16'd2, 2);
    exec("slt_g1", 5, 6, 7, 16'd0, 4);
    exec("mvi_55", 1, 1, 0, 16'h0055, 2);
    io.DIN = ins(8, 0, 1);
    tick();
    #1;
`ifdef PROC_MVNZ_EN
    chk("mvnz_g1.bus", io.BusWires, 16'h0055);
`else
    chk("mvnz_g1.bus", io.BusWires, 16'h0000);
`endif
    chk("mvnz_g1.done", 16'(io.Done), 16'd1);
    tick();
`ifdef PROC_MVNZ_EN
    rd("rd_mvnz_g1", 0, 16'h0055);
`else
    rd("rd_mvnz_g1", 0, 16'h0001);
`endif

    // NOP opcode
    io.DIN = ins(9, 0, 1);
    tick();
    #1;
    chk("nop.bus", io.BusWires, 16'h0000);
    chk("nop.done", 16'(io.Done), 16'd1);
    tick();

    // stall three cycles in T2 of an and
    exec("mvi_0f0f", 1, 2, 0, 16'h0F0F, 2);
    exec("mvi_00ff", 1, 3, 0, 16'h00FF, 2);
    io.DIN = ins(4, 2, 3);
    tick();
    #1;
    chk("and.t1bus", io.BusWires, 16'h0F0F);
    tick();
    io.Run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall.done", 16'(io.Done), 16'd0);
      chk("stall.bus", io.BusWires, 16'h00FF);
      tick();
    end
    io.Run = 1'b1;
    #1;
    chk("and.t2done", 16'(io.Done), 16'd0);
    tick();
    #1;
    chk("and.t3bus", io.BusWires, 16'h000F);
    chk("and.t3done", 16'(io.Done), 16'd1);
    tick();
    rd("rd_and", 2, 16'h000F);

    // reset mid-ALU
    io.DIN = ins(2, 2, 3);
    tick();
    tick();
    #2;
    Reset = 1'b1;
    #1;
    chk("rstmid.done", 16'(io.Done), 16'd0);
    chk("rstmid.bus", io.BusWires, 16'h0000);
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) rd("rd_after_rst", i, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/proc_multicycle_p.md
# proc_multicycle_p

Parametrised multicycle register-transfer processor: a single shared bus, a register file, an A/G accumulator pair and a step FSM executing one instruction per fetch from `DIN`. Successor to the fixed 16-bit/8-register processor. Adds:
- configurable data width and register count;
- a 4-bit opcode;
- `Run` as a stall qualifier on every step;
- a defined idle bus value and defined shift overflow;
- an optional conditional move.

Sits between the board-level switch/LED wrapper and the tester driving `DIN`/`Run`.

## Interface
Parameters:
- `DATA_W`, 16: width of bus, registers, A, G.
- `RAW`, 3: register-address width; `NREGS = 2**RAW` registers.
- Instruction width `IW = 4 + 2*RAW`; requires `DATA_W >= IW`. Instruction is `DIN[IW-1:0]` = {opcode[3:0], X[RAW-1:0], Y[RAW-1:0]}.

Ports:
- `Clock`, input, 1: single clock, all state updates on posedge.
- `Reset`, input, 1: asynchronous, active-high reset.
- `DIN`, input, DATA_W: instruction in T0; immediate in T1 of mvi.
- `Run`, input, 1: step enable; FSM advances and writes only when high.
- `Done`, output, 1: high during the final step of an instruction while `Run` = 1.
- `BusWires`, output, DATA_W: current shared-bus value.

## Operation
- FSM states T0 (fetch), T1, T2, T3. At posedge with `Run` = 0: state, IR, R*, A and G all hold.
- **T0:** `BusWires` = 0. If `Run`, IR <= instruction, go to T1.
- **T1:**
  - mv (0): bus = RY, RX <= bus, `Done`, go to T0.
  - mvi (1): bus = `DIN`, RX <= bus, `Done`, go to T0.
  - ALU ops (2–7): bus = RX, A <= bus, go to T2.
  - mvnz (8): see Configuration.
  - Opcodes 9–15: NOP; bus = 0, `Done`, go to T0.
- **T2:** bus = RY; G <= A op bus; go to T3.
  - add (2): A+B, modulo 2^DATA_W.
  - sub (3): A−B, modulo 2^DATA_W.
  - and (4): A&B.
  - slt (5): unsigned, result 1 if A<B, else 0.
  - sll (6), srl (7): A shifted by B; result 0 when B >= DATA_W.
- **T3:** bus = G, RX <= bus, `Done`, go to T0.
- X = Y is legal in every op; a read uses the pre-edge value.
- Reset (asynchronous, any state): state = T0; IR, A, G and all R* = 0. Therefore `Done` = 0 and `BusWires` = 0. An instruction in flight is abandoned with no further writes.

## Timing
- Latency with `Run` held high, including the T0 fetch:
  - mv, mvi, NOP, mvnz: 2 cycles.
  - ALU ops: 4 cycles.
- Each low cycle of `Run` adds exactly one cycle; a stall in T0 delays the fetch.
- `Done` and `BusWires` are combinational from state, IR, registers, `DIN` and `Run`. `Done` asserts in the cycle before the posedge that performs the final write.
- Back-to-back: the cycle after `Done` is T0; the next instruction is sampled at that cycle's posedge.
- For mvi, `DIN` must present the immediate during T1. It is sampled at the T1 posedge with `Run` = 1.

## Configuration
- Macro `PROC_MVNZ_EN`.
  - Defined: opcode 8 = mvnz. In T1, bus = RY; RX <= bus only if G != 0; `Done`; go to T0. G is unchanged.
  - Undefined: opcode 8 is a NOP like 9–15, with no register write.

## Test plan
- **Reset mid-ALU:** issue add, assert `Reset` in T2 → immediately `Done` = 0, `BusWires` = 0; all registers read 0 afterwards via mv.
- **mvi then add:** DATA_W=16. mvi R0,5; mvi R1,7; add R0,R1 → R0 = 12. `Done` high on the 2nd, 2nd and 4th cycle of each instruction respectively. mv R2,R0 shows bus = 0x000C in T1.
- **Wrap and shift:** R0 = 0xFFFF, R1 = 1.
  - add R0,R1 → R0 = 0x0000.
  - Then with R3 = 0x8000, R4 = 16: sll R3,R4 → R3 = 0.
  - srl with R4 = 15 → R3 = 1.
- **slt and sub:** R0 = 3, R1 = 9.
  - slt R0,R1 → R0 = 1.
  - Then R5 = 2: sub R5,R1 → R5 = 0xFFF9.
- **Stall:** hold `Run` = 0 for 3 cycles during T2 of an and → G and state unchanged, `Done` low; completes 3 cycles late with the correct result.
- **mvnz, both builds:**
  - G = 0 (from a prior slt false): mvnz R0,R1 → R0 unchanged.
  - G = 1: R0 <= R1 with `PROC_MVNZ_EN`; R0 unchanged without it; `Done` after 2 cycles in both builds.
